// File: rtl/fwrisc_mul_iter_if.sv
// fwrisc_mul_iter_if: request/response bundle for the
// iterative multiplier (operands in, result pulse out).
interface fwrisc_mul_iter_if;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  op;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out;
  logic        out_valid;

  modport master (
    output in_a, in_b, op, in_valid,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  in_a, in_b, op, in_valid,
    output in_ready, out, out_valid
  );
endinterface

// File: rtl/fwrisc_mul_iter.sv
// fwrisc_mul_iter: shift-add 32x32 multiplier returning the
// low or high half of the 64-bit product after 32/BPC steps.
module fwrisc_mul_iter #(
  parameter int BITS_PER_CYCLE = 1
) (
  input logic              clock,
  input logic              reset,
  fwrisc_mul_iter_if.slave bus
);

  localparam int STEPS = 32 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST = 5'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] acc_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [4:0]  cnt_q;
  logic        neg_q;
  logic        hi_q;
  logic        bad_q;
  logic [31:0] out_q;

  logic        accept;
  logic        op_ok;
  logic        sgn;
  logic        hi;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] part;
  logic [63:0] prod;
  logic [31:0] result;

  // decode the requested op into ok / signed / high-half
  always_comb begin
    op_ok = 1'b0;
    sgn   = 1'b0;
    hi    = 1'b0;
    case (bus.op)
      4'd3: op_ok = 1'b1;
      4'd4: begin
        op_ok = 1'b1;
        hi    = 1'b1;
      end
      4'd5: begin
        op_ok = 1'b1;
        sgn   = 1'b1;
      end
      4'd6: begin
        op_ok = 1'b1;
        sgn   = 1'b1;
        hi    = 1'b1;
      end
      default: ;
    endcase
  end

  assign mag_a = (sgn && bus.in_a[31]) ? (~bus.in_a + 32'd1)
                                       : bus.in_a;
  assign mag_b = (sgn && bus.in_b[31]) ? (~bus.in_b + 32'd1)
                                       : bus.in_b;

  // partial product of the low multiplier digit
  always_comb begin
    part = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_q[i]) part = part + (mcand_q << i);
    end
  end

  assign prod   = neg_q ? (~acc_q + 64'd1) : acc_q;
  assign result = bad_q ? 32'd0
                : (hi_q ? prod[63:32] : prod[31:0]);

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state and handshake outputs
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = op_ok ? BUSY : DONE;
        end
      end
      BUSY: if (cnt_q == LAST) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = (state_q == DONE) ? result : out_q;

  // operand latch, accumulate, and result hold
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
      bad_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      if (accept) begin
        acc_q    <= '0;
        mcand_q  <= {32'd0, mag_a};
        mplier_q <= mag_b;
        cnt_q    <= '0;
        neg_q    <= sgn & (bus.in_a[31] ^ bus.in_b[31]);
        hi_q     <= hi;
        bad_q    <= ~op_ok;
      end else if (state_q == BUSY) begin
        acc_q    <= acc_q + part;
        mcand_q  <= mcand_q << BITS_PER_CYCLE;
        mplier_q <= mplier_q >> BITS_PER_CYCLE;
        cnt_q    <= cnt_q + 5'd1;
      end
      if (state_q == DONE) out_q <= result;
    end
  end

endmodule

// File: tb/tb_fwrisc_mul_iter.sv
// tb_fwrisc_mul_iter: directed requests checked against a
// 64-bit arithmetic product model every cycle.
module tb_fwrisc_mul_iter;

  localparam int LAT = 33;

  logic clock = 1'b0;
  logic reset = 1'b1;

  fwrisc_mul_iter_if bus ();

  fwrisc_mul_iter #(.BITS_PER_CYCLE(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] val;
    int          lat;
    int          at;
  } exp_t;

  exp_t        q[$];
  int          vectors    = 0;
  int          miscompares = 0;
  int          negcnt     = 0;
  int          poscnt     = 0;
  logic        outstanding = 1'b0;
  logic [31:0] last_out   = 32'd0;

  function automatic logic [31:0] model(
    input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pu;
    logic [63:0] ps;
    pu = {32'd0, a} * {32'd0, b};
    ps = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    case (o)
      4'd3: return pu[31:0];
      4'd4: return pu[63:32];
      4'd5: return ps[31:0];
      4'd6: return ps[63:32];
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // accept monitor: snapshot expectations at the accept edge
  always @(posedge clock) begin
    exp_t e;
    poscnt++;
    if (reset && bus.in_valid && bus.in_ready) begin
      e.val = model(bus.op, bus.in_a, bus.in_b);
      e.lat = (bus.op >= 4'd3 && bus.op <= 4'd6) ? LAT : 1;
      e.at  = negcnt;
      q.push_back(e);
      outstanding = 1'b1;
    end
  end

  // compare process
  always @(negedge clock) begin
    exp_t e;
    negcnt++;
    if (!reset) begin
      q.delete();
      outstanding = 1'b0;
      last_out    = 32'd0;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_out", bus.out, 32'd0);
    end else begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, !outstanding});
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("result", bus.out, e.val);
          chk("latency", 32'(negcnt - e.at), 32'(e.lat));
          last_out = e.val;
        end
        outstanding = 1'b0;
      end else begin
        chk("out_hold", bus.out, last_out);
      end
    end
  end

  task automatic wait_accept(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic req(input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] expv,
                     input string nm);
    bit got;
    @(posedge clock);
    #1;
    bus.op = o;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    wait_accept(nm);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a = $urandom;
    bus.in_b = $urandom;
    bus.op = 4'($urandom_range(3, 6));
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.out_valid) begin
        got = 1;
        break;
      end
    end
    if (got) chk(nm, bus.out, expv);
    else chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int t0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.op = '0;
    bus.in_valid = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    chk("pin_mul", model(4'd3, 32'd3, 32'd5), 32'h0000000F);
    chk("pin_mulsh", model(4'd6, 32'h80000000, 32'h80000000),
        32'h40000000);

    req(4'd3, 32'd3, 32'd5, 32'h0000000F, "mul_3x5");
    req(4'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulh_ff");
    req(4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_ff");
    req(4'd5, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, "muls_m2x3");
    req(4'd6, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, "mulsh_m2x3");
    req(4'd6, 32'h80000000, 32'h80000000, 32'h40000000, "mulsh_min");
    req(4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulsh_m1");
    req(4'd5, 32'h80000000, 32'd1, 32'h80000000, "muls_min1");
    req(4'd4, 32'h80000000, 32'd2, 32'h00000001, "mulh_carry");
    req(4'd3, 32'h12345678, 32'h9ABCDEF0, 32'h242D2080, "mul_mix");
    req(4'd0, 32'd9, 32'd9, 32'h00000000, "bad_op0");
    req(4'd7, 32'd9, 32'd9, 32'h00000000, "bad_op7");

    // back-to-back with in_valid held high
    @(posedge clock);
    #1;
    bus.op = 4'd3;
    bus.in_a = 32'd1234;
    bus.in_b = 32'd5678;
    bus.in_valid = 1'b1;
    wait_accept("b2b_first");
    t0 = poscnt;
    #1;
    bus.op = 4'd6;
    bus.in_a = 32'hFFFFFFF9;
    bus.in_b = 32'h12345678;
    wait_accept("b2b_second");
    chk("b2b_gap", 32'(poscnt - t0), 32'd34);
    #1 bus.in_valid = 1'b0;
    repeat (40) @(posedge clock);

    // reset in the middle of an operation
    @(posedge clock);
    #1;
    bus.op = 4'd3;
    bus.in_a = 32'hDEADBEEF;
    bus.in_b = 32'h00001234;
    bus.in_valid = 1'b1;
    wait_accept("abort");
    #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (40) @(posedge clock);
    req(4'd3, 32'd7, 32'd6, 32'd42, "post_reset_7x6");

    repeat (5) @(posedge clock);
    chk("drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
